// File: rtl/regfile_2r1w_param.sv
// regfile_2r1w_param: parametrised 1W/2R register file with registered reads, bypass, zero reg and clear sweep
module regfile_2r1w_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CLR,
   output logic                  BUSY,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   input  logic                  RE1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic                  VALID_R1,
   input  logic                  RE2,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   output logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  VALID_R2
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {IDLE, SWEEP} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic accept, wr_en;
   logic [1:0] re, valid_r;
   logic [1:0][ADDR_WIDTH-1:0] addr_r;
   logic [1:0][DATA_WIDTH-1:0] rd_word, data_r;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         ptr <= '0;
      end else begin
         state <= state_nxt;
         ptr <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = (state == IDLE) ? (CLR ? SWEEP : IDLE)
                                  : ((ptr == ADDR_WIDTH'(DEPTH-1)) ? IDLE : SWEEP);
      ptr_nxt = (state == SWEEP) ? ptr + ADDR_WIDTH'(1) : '0;
   end

   // CLR wins over any access on the edge it is sampled
   always_comb begin
      BUSY = (state == SWEEP);
      accept = (state == IDLE) && !CLR;
      wr_en = accept && WE && !(ZERO_REG && ADDR_W == '0);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == SWEEP) begin
         mem[ptr] <= '0;
      end else if (wr_en) begin
         mem[ADDR_W] <= DATA_W;
      end
   end

   assign re = {RE2, RE1};
   assign addr_r = {ADDR_R2, ADDR_R1};

   for (genvar g = 0; g < 2; g++) begin : g_rd
      assign rd_word[g] = (ZERO_REG && addr_r[g] == '0) ? '0 :
                          (BYPASS && wr_en && ADDR_W == addr_r[g]) ? DATA_W : mem[addr_r[g]];
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            data_r[g] <= '0;
            valid_r[g] <= 1'b0;
         end else begin
            valid_r[g] <= accept && re[g];
            if (accept && re[g]) data_r[g] <= rd_word[g];
         end
      end
   end

   assign DATA_R1 = data_r[0];
   assign DATA_R2 = data_r[1];
   assign VALID_R1 = valid_r[0];
   assign VALID_R2 = valid_r[1];
endmodule

// File: doc/regfile_2r1w_param.md
# regfile_2r1w_param

Parametrised register file: one write port, two independent read ports with registered outputs, a per-port valid strobe and optional write-to-read bypass. It also has a hardwired-zero register option and a sequential clear engine that sweeps the array one word per cycle. It sits in the datapath next to the ALU as the next-generation general-purpose register file, generalising the fixed 32x32 file to arbitrary width and depth.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 1, 1: register 0 always reads 0 and writes to it are dropped
- BYPASS, 1, 1: a read of the address being written on the same edge returns DATA_W; 0: it returns the old contents

Ports:
- CLK  input  1  clock; all operations on the rising edge
- RST  input  1  reset; asynchronous, active-high; clears the array, outputs and FSM
- CLR  input  1  start sequential clear sweep (sampled at posedge)
- BUSY  output  1  high while the clear sweep runs
- WE  input  1  write enable
- ADDR_W  input  ADDR_WIDTH  write address
- DATA_W  input  DATA_WIDTH  write data
- RE1 / RE2  input  1  read enable, port 1 / 2
- ADDR_R1 / ADDR_R2  input  ADDR_WIDTH  read address, port 1 / 2
- DATA_R1 / DATA_R2  output  DATA_WIDTH  registered read data, port 1 / 2
- VALID_R1 / VALID_R2  output  1  one-cycle strobe: DATA_Rn was updated at this edge

## Operation
- The array is DEPTH x DATA_WIDTH flops. The FSM has two states: IDLE and SWEEP, with a pointer ptr[ADDR_WIDTH-1:0].
- RST high (async):
  - all registers go to 0
  - DATA_R1/2 = 0, VALID_R1/2 = 0, BUSY = 0
  - state = IDLE, ptr = 0
  - this holds for as long as RST is high, including mid-sweep.
- IDLE, CLR=1 at an edge:
  - state goes to SWEEP, ptr = 0, BUSY = 1
  - WE, RE1 and RE2 on that edge are ignored (CLR has priority)
  - VALID_R1/2 = 0
- SWEEP, each edge:
  - reg[ptr] = 0 and ptr increments
  - after clearing reg[DEPTH-1], state goes to IDLE and BUSY goes 0
  - CLR is ignored while in SWEEP (no restart)
  - WE, RE1 and RE2 are ignored; VALID_R1/2 = 0; DATA_R1/2 hold
- IDLE, CLR=0, write: if WE=1, reg[ADDR_W] = DATA_W. If ZERO_REG=1 and ADDR_W=0, the write is dropped.
- IDLE, CLR=0, read on port n:
  - REn=1: DATA_Rn gets reg[ADDR_Rn] and VALID_Rn = 1 for one cycle.
  - REn=0: DATA_Rn holds and VALID_Rn = 0.
- Same-address read and write on one edge:
  - BYPASS=1: DATA_Rn = DATA_W.
  - BYPASS=0: DATA_Rn = the pre-write value.
  - In both cases, if ZERO_REG=1 and the address is 0, DATA_Rn = 0.
- Both read ports may address the same register on the same edge; both return identical data.
- Out-of-range addresses cannot occur: DEPTH = 2**ADDR_WIDTH.

## Timing
- Read latency is 1 cycle: address and REn are sampled at edge k; DATA_Rn and VALID_Rn are valid after edge k, until the next edge.
- Write takes effect at edge k. A read at edge k+1 sees the new value, regardless of BYPASS.
- Clear: CLR sampled at edge k.
  - BUSY is high from edge k to edge k+DEPTH.
  - reg[i] is cleared at edge k+1+i.
  - The first accepted read or write is at edge k+DEPTH+1.
  - Total blocked window: DEPTH+1 edges, counting edge k.
- RST deassertion: the first operation is accepted at the first rising edge with RST=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive RST=1 mid-operation -> all DATA_Rn=0, VALID_Rn=0, BUSY=0 immediately. Reading every address after release returns 0.
- Write/read, default params: write 0xDEADBEEF to reg 7, then RE1=1 ADDR_R1=7 and RE2=1 ADDR_R2=7 next cycle -> both ports return 0xDEADBEEF with VALID high one cycle after. RE=0 -> DATA holds, VALID=0.
- Bypass: BYPASS=1, reg 3 = 0x11, same edge WE ADDR_W=3 DATA_W=0x22 and RE1 ADDR_R1=3 -> DATA_R1=0x22. BYPASS=0 build -> DATA_R1=0x11; next read returns 0x22.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to reg 0 -> read returns 0, including the same-edge bypass case. ZERO_REG=0 -> read returns 0xFFFFFFFF.
- Clear sweep:
  - Fill all 32 regs with index+1, pulse CLR -> BUSY high exactly 32 cycles; WE/RE and a second CLR during the sweep are ignored (no VALID, no writes land).
  - After the sweep all reads return 0, and a write on the first edge after BUSY falls is accepted.
- Parametrised build: DATA_WIDTH=8, ADDR_WIDTH=3 -> write/read all 8 regs, sweep takes 8 cycles, RST mid-sweep aborts with BUSY=0 and array 0.
